gnr_attractor_ctrl: RTL and testbench

//  Sequencer driving the GNR node array: loads a seed state, steps the nodes in a

---
 rtl/gnr_attractor_ctrl_pkg.sv | 22 ++
 rtl/gnr_attractor_ctrl_if.sv | 26 ++
 rtl/gnr_attractor_ctrl_result_reg.sv | 43 ++++
 rtl/gnr_attractor_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gnr_attractor_ctrl_pkg.sv
// Shared definitions for the GNR attractor controller.
//   gnr_state_e : sequencer states
//   step_w()    : width of step/period counters for a given pair budget
package gnr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUNA,
    ST_RUNB,
    ST_CMP,
    ST_PSTEP,
    ST_PCHK,
    ST_DONE
  } gnr_state_e;

  // Counters must be able to hold the budget value itself.
  function automatic int step_w(input int max_pairs);
    return $clog2(max_pairs + 1);
  endfunction

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Result port of the GNR attractor controller (valid/ready).
//   master : controller side, drives valid and result fields, receives ready
//   slave  : host side
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 6,
  parameter int STEP_W  = 11
) ();

  logic               res_valid;
  logic               res_ready;
  logic [STEP_W-1:0]  res_steps;
  logic [STEP_W-1:0]  res_period;
  logic [N_NODES-1:0] res_state;
  logic               res_timeout;

  modport master (
    output res_valid, res_steps, res_period, res_state, res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_steps, res_period, res_state, res_timeout,
    output res_ready
  );

endinterface

// File: rtl/gnr_attractor_ctrl_result_reg.sv
// gnr_result_reg: valid/ready holding register for the run result.
//   clk, rst_n   : clock, synchronous active-low reset
//   ld           : capture ld_* fields and raise res_valid
//   ld_steps     : meet step-pair count
//   ld_period    : attractor period
//   ld_state     : attractor state snapshot
//   ld_timeout   : budget exhausted flag
//   res          : result port (master side)
module gnr_result_reg
  import gnr_ctrl_pkg::*;
#(
  parameter int N_NODES = 6,
  parameter int STEP_W  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [STEP_W-1:0]  ld_steps,
  input  logic [STEP_W-1:0]  ld_period,
  input  logic [N_NODES-1:0] ld_state,
  input  logic               ld_timeout,
  gnr_attractor_ctrl_if.master res
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res.res_valid   <= 1'b0;
      res.res_steps   <= '0;
      res.res_period  <= '0;
      res.res_state   <= '0;
      res.res_timeout <= 1'b0;
    end else if (ld) begin
      res.res_valid   <= 1'b1;
      res.res_steps   <= ld_steps;
      res.res_period  <= ld_period;
      res.res_state   <= ld_state;
      res.res_timeout <= ld_timeout;
    end else if (res.res_valid && res.res_ready) begin
      res.res_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: tortoise/hare sequencer for a GNR node array.
// Loads a seed, steps the nodes in pairs until s0==s1, then steps the hare
// alone to measure the attractor period, and returns the result over a
// valid/ready port.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, seed         : launch a run (sampled in IDLE) with initial state
//   reset_nos           : node load strobe, init_state is the load value
//   start_s0, start_s1  : tortoise / hare step enables
//   net_s0, net_s1      : node array s0 / s1 vectors
//   busy                : controller not idle
//   res                 : result port (master side)
// Optional macro GNR_TRACE_EN adds trace_valid / trace_state outputs that
// report net_s1 once per CMP and PCHK state.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int N_NODES   = 6,
  parameter int MAX_PAIRS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] seed,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] net_s0,
  input  logic [N_NODES-1:0] net_s1,
  output logic               busy,
`ifdef GNR_TRACE_EN
  output logic               trace_valid,
  output logic [N_NODES-1:0] trace_state,
`endif
  gnr_attractor_ctrl_if.master res
);

  localparam int STEP_W = step_w(MAX_PAIRS);
  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_PAIRS);

  gnr_state_e         state;
  logic [STEP_W-1:0]  j;
  logic [STEP_W-1:0]  period;
  logic [N_NODES-1:0] snapshot;
  logic               timeout_q;
  logic               ld;
  logic [STEP_W-1:0]  j_inc;
  logic [STEP_W-1:0]  period_inc;

  assign j_inc      = j + 1'b1;
  assign period_inc = period + 1'b1;

  // Strobes are registered: each one is set on the edge that enters the
  // state in which it must be high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      reset_nos  <= 1'b0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      init_state <= '0;
      busy       <= 1'b0;
      j          <= '0;
      period     <= '0;
      snapshot   <= '0;
      timeout_q  <= 1'b0;
      ld         <= 1'b0;
`ifdef GNR_TRACE_EN
      trace_valid <= 1'b0;
      trace_state <= '0;
`endif
    end else begin
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;
      ld        <= 1'b0;
`ifdef GNR_TRACE_EN
      trace_valid <= 1'b0;
      if (state == ST_CMP || state == ST_PCHK) begin
        trace_valid <= 1'b1;
        trace_state <= net_s1;
      end
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            init_state <= seed;
            reset_nos  <= 1'b1;
            busy       <= 1'b1;
            j          <= '0;
            period     <= '0;
            timeout_q  <= 1'b0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= ST_RUNA;
        end
        ST_RUNA: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= ST_RUNB;
        end
        ST_RUNB: begin
          state <= ST_CMP;
        end
        ST_CMP: begin
          j <= j_inc;
          if (net_s0 == net_s1) begin
            snapshot <= net_s0;
            period   <= '0;
            start_s1 <= 1'b1;
            state    <= ST_PSTEP;
          end else if (j_inc == MAX_CNT) begin
            timeout_q <= 1'b1;
            ld        <= 1'b1;
            state     <= ST_DONE;
          end else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            state    <= ST_RUNA;
          end
        end
        ST_PSTEP: begin
          period <= period_inc;
          state  <= ST_PCHK;
        end
        ST_PCHK: begin
          if (net_s1 == snapshot) begin
            ld    <= 1'b1;
            state <= ST_DONE;
          end else if (period == MAX_CNT) begin
            timeout_q <= 1'b1;
            ld        <= 1'b1;
            state     <= ST_DONE;
          end else begin
            start_s1 <= 1'b1;
            state    <= ST_PSTEP;
          end
        end
        ST_DONE: begin
          if (res.res_valid && res.res_ready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // j and period hold their final values while DONE is entered, so they
  // feed the result register directly.
  gnr_result_reg #(
    .N_NODES (N_NODES),
    .STEP_W  (STEP_W)
  ) u_result_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld),
    .ld_steps   (j),
    .ld_period  (period),
    .ld_state   (snapshot),
    .ld_timeout (timeout_q),
    .res        (res)
  );

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two instances (6 nodes / 1024 pairs and
// 3 nodes / 4 pairs) each driving a behavioural node array; results are
// compared with a sequence-based reference of the attractor search.
module tb_gnr_attractor_ctrl;
  import gnr_ctrl_pkg::*;

  localparam int A_MAX = 1024;
  localparam int B_MAX = 4;
  localparam int A_SW  = step_w(A_MAX);
  localparam int B_SW  = step_w(B_MAX);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, ready, sel;
  logic [5:0] seed;
  int         mode;
  logic [5:0] lut [64];
  int         errors = 0;
  int         checks = 0;

  // network update function
  function automatic logic [5:0] fmap(input logic [5:0] x, input logic [5:0] mask);
    case (mode)
      0:       return x;
      1:       return (x + 6'd1) & 6'h07;
      default: return lut[x] & mask;
    endcase
  endfunction

  // ---------------- instance A ----------------
  logic       a_start, a_reset_nos, a_s0, a_s1, a_busy;
  logic [5:0] a_init, a_t, a_h;
  logic       a_pass;
  gnr_attractor_ctrl_if #(.N_NODES(6), .STEP_W(A_SW)) a_if ();
  assign a_start = start && !sel;
  assign a_if.res_ready = ready;
`ifdef GNR_TRACE_EN
  logic       a_tv;
  logic [5:0] a_ts;
`endif

  gnr_attractor_ctrl #(.N_NODES(6), .MAX_PAIRS(A_MAX)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .seed(seed),
    .reset_nos(a_reset_nos), .init_state(a_init),
    .start_s0(a_s0), .start_s1(a_s1),
    .net_s0(a_t), .net_s1(a_h), .busy(a_busy),
`ifdef GNR_TRACE_EN
    .trace_valid(a_tv), .trace_state(a_ts),
`endif
    .res(a_if)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      a_t <= '0; a_h <= '0; a_pass <= 1'b1;
    end else if (a_reset_nos) begin
      a_t <= a_init; a_h <= a_init; a_pass <= 1'b1;
    end else begin
      if (a_s1) a_h <= fmap(a_h, 6'h3f);
      if (a_s0) begin
        a_pass <= ~a_pass;
        if (a_pass) a_t <= fmap(a_t, 6'h3f);
      end
    end
  end

  // ---------------- instance B ----------------
  logic       b_start, b_reset_nos, b_s0, b_s1, b_busy;
  logic [2:0] b_init, b_t, b_h;
  logic       b_pass;
  gnr_attractor_ctrl_if #(.N_NODES(3), .STEP_W(B_SW)) b_if ();
  assign b_start = start && sel;
  assign b_if.res_ready = ready;
`ifdef GNR_TRACE_EN
  logic       b_tv;
  logic [2:0] b_ts;
`endif

  gnr_attractor_ctrl #(.N_NODES(3), .MAX_PAIRS(B_MAX)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .seed(seed[2:0]),
    .reset_nos(b_reset_nos), .init_state(b_init),
    .start_s0(b_s0), .start_s1(b_s1),
    .net_s0(b_t), .net_s1(b_h), .busy(b_busy),
`ifdef GNR_TRACE_EN
    .trace_valid(b_tv), .trace_state(b_ts),
`endif
    .res(b_if)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      b_t <= '0; b_h <= '0; b_pass <= 1'b1;
    end else if (b_reset_nos) begin
      b_t <= b_init; b_h <= b_init; b_pass <= 1'b1;
    end else begin
      if (b_s1) b_h <= 3'(fmap({3'b0, b_h}, 6'h07));
      if (b_s0) begin
        b_pass <= ~b_pass;
        if (b_pass) b_t <= 3'(fmap({3'b0, b_t}, 6'h07));
      end
    end
  end

  // ---------------- observation mux ----------------
  logic        obs_valid, obs_timeout, obs_busy;
  logic [10:0] obs_steps, obs_period;
  logic [5:0]  obs_state;
  logic [2:0]  obs_strobes;
  assign obs_valid   = sel ? b_if.res_valid   : a_if.res_valid;
  assign obs_timeout = sel ? b_if.res_timeout : a_if.res_timeout;
  assign obs_busy    = sel ? b_busy : a_busy;
  assign obs_steps   = sel ? 11'(b_if.res_steps)  : 11'(a_if.res_steps);
  assign obs_period  = sel ? 11'(b_if.res_period) : 11'(a_if.res_period);
  assign obs_state   = sel ? {3'b0, b_if.res_state} : a_if.res_state;
  assign obs_strobes = sel ? {b_reset_nos, b_s0, b_s1} : {a_reset_nos, a_s0, a_s1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk x_k = f^k(seed); first j>=1 with x_j == x_2j is the
  // meet, period is the smallest p with f^p(x_j) == x_j. Latency counts
  // LOAD, three cycles per pair, two per period step and one register cycle.
  logic [5:0] xs [0:2*A_MAX];
  task automatic ref_run(input logic [5:0] sd, input logic [5:0] mask, input int maxp,
                         output int steps, output int period, output int st,
                         output bit to, output int lat);
    bit found;
    logic [5:0] y;
    steps = 0; period = 0; st = 0; to = 1'b0; found = 1'b0;
    xs[0] = sd & mask;
    for (int k = 1; k <= 2 * maxp; k++) xs[k] = fmap(xs[k-1], mask);
    for (int k = 1; k <= maxp; k++)
      if (!found && xs[k] == xs[2*k]) begin found = 1'b1; steps = k; end
    if (!found) begin
      to = 1'b1; lat = 1 + 3 * maxp + 1;
      return;
    end
    st = int'(xs[steps]);
    found = 1'b0;
    y = xs[steps];
    for (int p = 1; p <= maxp; p++) begin
      y = fmap(y, mask);
      if (!found && y == xs[steps]) begin found = 1'b1; period = p; end
    end
    if (!found) begin
      to = 1'b1; lat = 1 + 3 * steps + 2 * maxp + 1;
    end else begin
      lat = 1 + 3 * steps + 2 * period + 1;
    end
  endtask

  task automatic do_run(input bit s, input logic [5:0] sd, input bit hold);
    int e_steps, e_period, e_state, e_lat, lat;
    bit e_to;
    ref_run(sd, s ? 6'h07 : 6'h3f, s ? B_MAX : A_MAX, e_steps, e_period, e_state, e_to, e_lat);
    sel = s; seed = sd; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!obs_valid && lat < 5000) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check_eq("res_valid", obs_valid, 1);
    check_eq("latency", lat, e_lat);
    check_eq("busy_done", obs_busy, 1);
    check_eq("res_timeout", obs_timeout, e_to);
    if (!e_to) begin
      check_eq("res_steps", obs_steps, e_steps);
      check_eq("res_period", obs_period, e_period);
      check_eq("res_state", obs_state, e_state);
    end
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        start = i[0];
        seed = 6'($urandom_range(0, 63));
        @(posedge clk); @(negedge clk);
      end
      start = 1'b0;
      check_eq("hold_valid", obs_valid, 1);
      check_eq("hold_busy", obs_busy, 1);
      check_eq("hold_steps", obs_steps, e_steps);
      check_eq("hold_period", obs_period, e_period);
      check_eq("hold_state", obs_state, e_state);
    end
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    check_eq("accept_valid", obs_valid, 0);
    check_eq("accept_busy", obs_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0; seed = '0; mode = 0;
    for (int i = 0; i < 64; i++) lut[i] = 6'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_busy", obs_busy, 0);
      check_eq("rst_valid", obs_valid, 0);
      check_eq("rst_strobes", obs_strobes, 0);
      check_eq("rst_steps", obs_steps, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // fixed point, seed 5
    mode = 0;
    do_run(1'b0, 6'd5, 1'b0);
    // 8-cycle ring from 0, then hold in DONE with start pulses
    mode = 1;
    do_run(1'b0, 6'd0, 1'b1);
    // same ring against a 4-pair budget
    do_run(1'b1, 6'd0, 1'b0);
    // back-to-back fixed points
    mode = 0;
    do_run(1'b0, 6'd3, 1'b0);
    do_run(1'b0, 6'd6, 1'b0);

    // reset during RUNB
    sel = 1'b0; seed = 6'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_eq("runb_strobes", obs_strobes, 3'b011);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("abort_busy", obs_busy, 0);
    check_eq("abort_strobes", obs_strobes, 0);
    check_eq("abort_valid", obs_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // random networks
    mode = 2;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 64; i++) lut[i] = 6'($urandom_range(0, 63));
      do_run(r[0], 6'($urandom_range(0, 63)), r % 5 == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
